mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single shared 32-bit memory port. Port 0 serves instruction fetch, port 1 serves load/store. The block grants one requester at a time using round-robin priority and latches that requester's address, write enable and write data. It then drives the memory for a fixed `MEM_LAT` cycles and returns read data with a one-cycle completion pulse. `mem_sel` reports the current owner so the datapath's 2-to-1 32-bit muxes can steer per-port signals.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter and sequencer sharing one 32-bit memory port between
//   an instruction-fetch requester (port 0) and a load/store requester
//   (port 1). A granted request is latched, driven to memory for MEM_LAT
//   cycles, and completed with a one-cycle rvalid pulse to its owner.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   req/addr/we/wdata 0,1 : per-port request and its fields
//   gnt0, gnt1            : one-cycle grant pulses (fields captured that edge)
//   rvalid0, rvalid1      : one-cycle completion pulses (reads and writes)
//   rdata                 : shared read data, qualified by rvalid0/rvalid1
//   mem_en/we/addr/wdata  : registered memory command
//   mem_rdata             : memory read data, valid in the last ACCESS cycle
//   mem_sel               : owner of the current or most recent transaction
//   busy                  : high while an access is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_sel,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Countdown start: the grant cycle is itself the first ACCESS cycle.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        mem_sel_q, mem_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_en_q, mem_en_d;
  logic        busy_q, busy_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        winner_s;

  // Next-state logic: arbitration in IDLE, countdown and completion in ACCESS.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = mem_en_q;
    busy_d      = busy_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    winner_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes next.
          if (req0 && req1) begin
            winner_s = ~last_q;
          end else begin
            winner_s = req1;
          end
          mem_sel_d = winner_s;
          last_d    = winner_s;
          if (winner_s) begin
            mem_addr_d  = addr1;
            mem_we_d    = we1;
            mem_wdata_d = wdata1;
            gnt1_d      = 1'b1;
          end else begin
            mem_addr_d  = addr0;
            mem_we_d    = we0;
            mem_wdata_d = wdata0;
            gnt0_d      = 1'b1;
          end
          cnt_d    = CNT_INIT;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          mem_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Writes acknowledge without disturbing the last read result.
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          if (mem_sel_q) begin
            rvalid1_d = 1'b1;
          end else begin
            rvalid0_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      busy_q      <= busy_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel   = mem_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Three instances (MEM_LAT = 1, 2, 3)
//   share the same stimulus; each scenario resets and then checks only the
//   instance whose latency it targets. Outputs are sampled 1 time unit after
//   the rising edge; cycle Tk is the period following the k-th edge after the
//   request is first presented (T0).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic [31:0] mem_rdata = 32'd0;

  logic [2:0]  gnt0_v, gnt1_v, rvalid0_v, rvalid1_v;
  logic [2:0]  mem_en_v, mem_we_v, mem_sel_v, busy_v;
  logic [31:0] rdata_v     [3];
  logic [31:0] mem_addr_v  [3];
  logic [31:0] mem_wdata_v [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(g + 1)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .addr0     (addr0),
      .addr1     (addr1),
      .we0       (we0),
      .we1       (we1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0_v[g]),
      .gnt1      (gnt1_v[g]),
      .rvalid0   (rvalid0_v[g]),
      .rvalid1   (rvalid1_v[g]),
      .rdata     (rdata_v[g]),
      .mem_en    (mem_en_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata),
      .mem_sel   (mem_sel_v[g]),
      .busy      (busy_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {gnt0, gnt1, rvalid0, rvalid1} of instance i
  function automatic logic [31:0] flags(input int i);
    return {28'd0, gnt0_v[i], gnt1_v[i], rvalid0_v[i], rvalid1_v[i]};
  endfunction

  // {mem_en, mem_we, mem_sel, busy} of instance i
  function automatic logic [31:0] ctl(input int i);
    return {28'd0, mem_en_v[i], mem_we_v[i], mem_sel_v[i], busy_v[i]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_b;

    // Reset state of every instance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_flags", flags(i), 32'd0);
      check_eq("rst_ctl", ctl(i), 32'd0);
      check_eq("rst_data", rdata_v[i] | mem_addr_v[i] | mem_wdata_v[i], 32'd0);
    end

    // MEM_LAT=1: port 0 read of 0x40 returning 0xDEADBEEF.
    addr0 = 32'h0000_0040; we0 = 1'b0; req0 = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();                                   // T1
    check_eq("l1_t1_flags", flags(0), 32'h8);
    check_eq("l1_t1_ctl",   ctl(0),   32'h9); // en, busy, sel=0
    check_eq("l1_t1_addr",  mem_addr_v[0], 32'h0000_0040);
    req0 = 1'b0;
    tick();                                   // T2
    check_eq("l1_t2_flags", flags(0), 32'h2);
    check_eq("l1_t2_ctl",   ctl(0),   32'h0);
    check_eq("l1_t2_rdata", rdata_v[0], 32'hDEAD_BEEF);
    tick();                                   // T3
    check_eq("l1_t3_flags", flags(0), 32'h0);

    // MEM_LAT=2: both ports request continuously -> grants 0,1,0,1 every 3 cycles.
    do_reset();
    addr0 = 32'h0000_1000; addr1 = 32'h0000_2000; mem_rdata = 32'h0BAD_F00D;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_b = 4'd0;
      if (k == 1 || k == 7)  exp_b = 4'h8;
      if (k == 4 || k == 10) exp_b = 4'h4;
      if (k == 3 || k == 9)  exp_b = 4'h2;
      if (k == 6 || k == 12) exp_b = 4'h1;
      check_eq($sformatf("rr_t%0d_flags", k), flags(1), {28'd0, exp_b});
      if (k == 4) check_eq("rr_t4_addr", mem_addr_v[1], 32'h0000_2000);
    end
    req0 = 1'b0; req1 = 1'b0;

    // MEM_LAT=3: port 0 read, port 1 write raised during the read's ACCESS.
    do_reset();
    addr0 = 32'h0000_0080; we0 = 1'b0; req0 = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();                                   // T1
    check_eq("rw_t1_flags", flags(2), 32'h8);
    req0 = 1'b0;
    tick();                                   // T2
    addr1 = 32'h0000_0100; wdata1 = 32'h1234_5678; we1 = 1'b1; req1 = 1'b1;
    tick();                                   // T3
    check_eq("rw_t3_flags", flags(2), 32'h0);
    check_eq("rw_t3_ctl",   ctl(2),   32'h9);
    tick();                                   // T4
    check_eq("rw_t4_flags", flags(2), 32'h2);
    check_eq("rw_t4_rdata", rdata_v[2], 32'hCAFE_F00D);
    mem_rdata = 32'hBAD0_BAD0;
    tick();                                   // T5: write granted
    check_eq("rw_t5_flags", flags(2), 32'h4);
    req1 = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      if (k > 5) tick();
      check_eq($sformatf("wr_t%0d_ctl", k), ctl(2), 32'hF);
      check_eq($sformatf("wr_t%0d_addr", k), mem_addr_v[2], 32'h0000_0100);
      check_eq($sformatf("wr_t%0d_wdata", k), mem_wdata_v[2], 32'h1234_5678);
    end
    tick();                                   // T8
    check_eq("wr_t8_flags", flags(2), 32'h1);
    check_eq("wr_t8_ctl",   ctl(2),   32'h2); // sel stays 1
    check_eq("wr_t8_rdata", rdata_v[2], 32'hCAFE_F00D);

    // MEM_LAT=3: reset in the second ACCESS cycle, then a tie goes to port 0.
    do_reset();
    addr0 = 32'h0000_0300; req0 = 1'b1;
    tick();                                   // T1
    check_eq("rs_t1_flags", flags(2), 32'h8);
    req0 = 1'b0;
    tick();                                   // T2
    #1;
    reset = 1'b1;
    #1;
    check_eq("rs_async_ctl",  ctl(2), 32'h0);
    check_eq("rs_async_addr", mem_addr_v[2], 32'd0);
    tick();
    tick();
    check_eq("rs_hold_flags", flags(2), 32'h0);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check_eq("rs_tie_flags", flags(2), 32'h8);
    req0 = 1'b0; req1 = 1'b0;

    // MEM_LAT=3: req0 pulsed only during port 1 ACCESS -> ignored.
    do_reset();
    addr1 = 32'h0000_0400; we1 = 1'b0; req1 = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_b = 4'd0;
      if (k == 1) exp_b = 4'h4;
      if (k == 4) exp_b = 4'h1;
      check_eq($sformatf("wd_t%0d_flags", k), flags(2), {28'd0, exp_b});
      if (k == 1) req1 = 1'b0;
      if (k == 2) req0 = 1'b1;
      if (k == 3) req0 = 1'b0;
    end
    check_eq("wd_busy", ctl(2), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
